// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern generators.
//   LFSR_DEFAULT_WIDTH/TAPS/SEED : 4-bit maximal-length configuration, x^4 + x^3 + 1
//   lfsr_default_t               : state type for the default configuration
//   lfsr_next()                  : reference next-state function for widths 2..32
package lfsr_pkg;

  localparam int unsigned LFSR_DEFAULT_WIDTH = 4;
  localparam logic [3:0]  LFSR_DEFAULT_TAPS  = 4'b1100;
  localparam logic [3:0]  LFSR_DEFAULT_SEED  = 4'b0001;

  typedef logic [LFSR_DEFAULT_WIDTH-1:0] lfsr_default_t;

  // Next state of a Fibonacci LFSR of the given width. Bits above 'width'
  // are ignored. The all-zero state recovers to 1, which mirrors the
  // hardware lockup guard when it is run with the default seed.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int unsigned width);
    logic [31:0] mask;
    logic [31:0] cur;
    logic        fb;
    if (width >= 32) mask = '1;
    else             mask = (32'h1 << width) - 32'h1;
    cur = state & mask;
    fb  = ^(cur & taps);
    if (cur == '0) return 32'h1;
    return ((cur << 1) | {31'h0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational feedback for a Fibonacci LFSR: XOR of every state bit whose
// tap-mask bit is set.
//   state : current register contents
//   taps  : feedback tap mask (bit i set -> state bit i contributes)
//   fb    : feedback bit that gets inserted at bit 0
module lfsr_feedback #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] taps,
  output logic             fb
);

  assign fb = ^(state & taps);

endmodule

// File: rtl/lfsr4_gen.sv
// Free-running Fibonacci LFSR pattern generator. It advances one step on
// every rising clock edge while out of reset. There is no enable and no load.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; loads SEED on the edge
//   lfsr  : register state, driven straight from the flops
module lfsr4_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_DEFAULT_TAPS,
  parameter logic [WIDTH-1:0] SEED  = LFSR_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] lfsr
);

  // An all-zero seed would lock the register up, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state;
  logic             fb;

  lfsr_feedback #(
    .WIDTH (WIDTH)
  ) u_feedback (
    .state (state),
    .taps  (TAPS),
    .fb    (fb)
  );

  // Reset wins over everything. The zero guard pulls an upset or
  // uninitialised register back onto the sequence after one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED_EFF;
    end else if (state == '0) begin
      state <= SEED_EFF;
    end else begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

  assign lfsr = state;

  // All-zero may be seen for at most one sampled cycle out of reset.
  a_no_zero_lockup : assert property (
    @(posedge clk) disable iff (!rst_n)
      !((state == '0) && ($past(state) == '0))
  );

endmodule

// File: tb/tb_lfsr4_gen.sv
// Bench for lfsr4_gen. The driver pushes hand-computed expected states into a
// queue. The monitor pops one entry after each rising edge and compares it
// with the output. A second instance covers the 5-bit configuration.
module tb_lfsr4_gen;

  logic       clk;
  logic       rst_n;
  logic       rst5_n;
  logic [3:0] lfsr;
  logic [4:0] lfsr5;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];
  string      name_q[$];

  // Default sequence starting from the seed; index 15 is the wrap back to 0001.
  logic [3:0] seq [0:15];

  lfsr4_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  lfsr4_gen #(
    .WIDTH (5),
    .TAPS  (5'b10100),
    .SEED  (5'b00001)
  ) dut5 (
    .clk   (clk),
    .rst_n (rst5_n),
    .lfsr  (lfsr5)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n  = 1'b0;
    rst5_n = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [3:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (lfsr !== e) begin
        failures++;
        $display("FAIL %s got=%b exp=%b t=%0t", n, lfsr, e, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Set rst_n away from the edge, queue the state expected after the next edge.
  task automatic drive_step(input logic r, input logic [3:0] e, input string n);
    @(negedge clk);
    rst_n = r;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
  endtask

  task automatic check_val(input string n, input logic [31:0] got, input logic [31:0] e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] seen4;
    logic [31:0] seen5;
    int          period5;

    seq[0]  = 4'b0001; seq[1]  = 4'b0010; seq[2]  = 4'b0100; seq[3]  = 4'b1001;
    seq[4]  = 4'b0011; seq[5]  = 4'b0110; seq[6]  = 4'b1101; seq[7]  = 4'b1010;
    seq[8]  = 4'b0101; seq[9]  = 4'b1011; seq[10] = 4'b0111; seq[11] = 4'b1111;
    seq[12] = 4'b1110; seq[13] = 4'b1100; seq[14] = 4'b1000; seq[15] = 4'b0001;

    // Reset: one edge low, then three more edges low.
    drive_step(1'b0, 4'b0001, "reset");
    for (int i = 0; i < 3; i++) drive_step(1'b0, 4'b0001, "reset_hold");

    // Release and walk the whole period, including the 1000 -> 0001 wrap.
    for (int i = 1; i <= 15; i++) drive_step(1'b1, seq[i], $sformatf("seq%0d", i));

    // Second period: confirm every nonzero code appears exactly once.
    seen4 = '0;
    for (int i = 1; i <= 15; i++) begin
      drive_step(1'b1, seq[i], $sformatf("period%0d", i));
      #2;
      if (seen4[lfsr] && i != 15) begin
        checks++;
        failures++;
        $display("FAIL unique4 got=repeat_%b exp=unique", lfsr);
      end
      seen4[lfsr] = 1'b1;
    end
    check_val("coverage4", 32'(seen4), 32'h0000_FFFE);

    // Mid-run reset at 1101.
    for (int i = 1; i <= 6; i++) drive_step(1'b1, seq[i], $sformatf("adv%0d", i));
    drive_step(1'b0, 4'b0001, "midrst");
    drive_step(1'b1, 4'b0010, "post_midrst");

    // Lockup guard: plant 0000 and expect the seed on the next edge.
    @(negedge clk);
    force dut.state = 4'b0000;
    #1;
    release dut.state;
    check_val("forced_zero", 32'(lfsr), 32'h0);
    exp_q.push_back(4'b0001);
    name_q.push_back("lockup_guard");
    @(posedge clk);
    drive_step(1'b1, 4'b0010, "after_guard");

    // 5-bit configuration: hand values for the first steps, then the period.
    @(negedge clk);
    rst5_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("w5_reset", 32'(lfsr5), 32'h01);
    @(negedge clk);
    rst5_n = 1'b1;
    seen5   = 32'h0000_0002;
    period5 = 0;
    for (int i = 1; i <= 40 && period5 == 0; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) check_val("w5_step1", 32'(lfsr5), 32'h02);
      if (i == 3) check_val("w5_step3", 32'(lfsr5), 32'h09);
      if (i == 4) check_val("w5_step4", 32'(lfsr5), 32'h12);
      if (lfsr5 == 5'd1) begin
        period5 = i;
      end else begin
        if (seen5[lfsr5]) begin
          checks++;
          failures++;
          $display("FAIL unique5 got=repeat_%b exp=unique", lfsr5);
        end
        seen5[lfsr5] = 1'b1;
      end
    end
    check_val("w5_period", 32'(period5), 32'd31);
    check_val("coverage5", seen5, 32'hFFFF_FFFE);

    // Let the monitor drain anything still queued.
    repeat (2) @(posedge clk);
    #2;
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
